// File: rtl/debounce.sv
// Synchronizing debouncer: a level on `in` reaches `out` after STABLE_CYCLES stable samples.
// Optional feature macro: DEBOUNCE_SYNC_EN selects a 2-flop synchronizer front end.
module debounce #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic in,
    output logic out,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_CHK_HIGH,
        ST_HIGH,
        ST_CHK_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             s;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], in};
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[1];
`else
    logic sync_q, sync_d;

    always_comb begin
        sync_d = in;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    // A single-cycle qualification skips the CHK states entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LOW: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_CHK_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_CHK_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_CHK_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_CHK_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in registers.
    always_comb begin
        out_d  = (state_d == ST_HIGH) || (state_d == ST_CHK_LOW);
        busy_d = (state_d == ST_CHK_HIGH) || (state_d == ST_CHK_LOW);
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: run-length reference model plus directed literal checks.
module tb_debounce;

    localparam int S = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic n_rst;
    logic in;
    logic out;
    logic busy;

    int checks   = 0;
    int failures = 0;

    debounce #(
        .STABLE_CYCLES(S),
        .CNT_W        (4)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .in   (in),
        .out  (out),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: out follows s once s has differed from out for S straight samples.
    bit       m_valid = 1'b0;
    bit       m_out;
    bit       m_busy;
    bit       last_s;
    int       run;
    bit [1:0] lag;

    always @(posedge clk) begin
        bit sf;
        int r;
        bit o;
        if (!n_rst) begin
            m_out   <= 1'b0;
            m_busy  <= 1'b0;
            run     <= 0;
            last_s  <= 1'b0;
            lag     <= 2'b00;
            m_valid <= 1'b1;
        end else begin
            sf = lag[LAT-1];
            r  = (run > 0 && sf == last_s) ? run + 1 : 1;
            if (r > 1000) r = 1000;
            o  = (sf != m_out && r >= S) ? sf : m_out;
            m_out  <= o;
            m_busy <= (sf != o);
            run    <= r;
            last_s <= sf;
            lag    <= {lag[0], in};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_out", out, m_out);
            chk("model_busy", busy, m_busy);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int busy_cnt;
    bit out_seen;

    initial begin
        n_rst = 1'b0;
        in    = 1'b1;

        // Reset held with in high
        cyc(1);
        chk("rst_out0", out, 1'b0);
        chk("rst_busy0", busy, 1'b0);
        cyc(1);
        chk("rst_out1", out, 1'b0);
        chk("rst_busy1", busy, 1'b0);
        n_rst = 1'b1;
        cyc(LAT + S - 1);
        chk("rst_rel_out_early", out, 1'b0);
        cyc(1);
        chk("rst_rel_out_rise", out, 1'b1);

        // Clean fall
        in = 1'b0;
        cyc(LAT + S - 1);
        chk("fall_out_early", out, 1'b1);
        chk("fall_busy", busy, 1'b1);
        cyc(1);
        chk("fall_out", out, 1'b0);
        chk("fall_busy_end", busy, 1'b0);
        cyc(3);

        // Clean rise
        in = 1'b1;
        cyc(LAT);
        chk("rise_busy_pre", busy, 1'b0);
        cyc(1);
        chk("rise_busy_on", busy, 1'b1);
        cyc(S - 2);
        chk("rise_busy_last", busy, 1'b1);
        chk("rise_out_early", out, 1'b0);
        cyc(1);
        chk("rise_out", out, 1'b1);
        chk("rise_busy_off", busy, 1'b0);
        cyc(10 - LAT - S);

        // Fall, then toggle back three cycles later
        in = 1'b0;
        cyc(LAT + S);
        chk("fall2_out", out, 1'b0);
        cyc(3);
        in = 1'b1;
        cyc(LAT + S - 1);
        chk("tog_out_early", out, 1'b0);
        cyc(1);
        chk("tog_out", out, 1'b1);
        in = 1'b0;
        cyc(8);
        chk("tog_back_low", out, 1'b0);

        // Bounce rejection
        in = 1'b1;
        cyc(2);
        in = 1'b0;
        cyc(1);
        in = 1'b1;
        cyc(LAT + S - 1);
        chk("bounce_out_early", out, 1'b0);
        cyc(1);
        chk("bounce_out", out, 1'b1);
        in = 1'b0;
        cyc(8);
        chk("bounce_back_low", out, 1'b0);

        // Short pulse
        busy_cnt = 0;
        out_seen = 1'b0;
        in = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) in = 1'b0;
            cyc(1);
            if (busy) busy_cnt++;
            if (out) out_seen = 1'b1;
        end
        chk("pulse_out_never", out_seen, 1'b0);
        chk("pulse_busy3", busy_cnt == 3, 1'b1);

        // Reset in the middle of a qualification
        in = 1'b1;
        cyc(LAT + 1);
        chk("mid_busy", busy, 1'b1);
        n_rst = 1'b0;
        cyc(1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_out", out, 1'b0);
        n_rst = 1'b1;
        cyc(LAT + S - 1);
        chk("mid_req_early", out, 1'b0);
        cyc(1);
        chk("mid_req_out", out, 1'b1);

        // Random bouncing, model-checked each cycle
        for (int i = 0; i < 80; i++) begin
            in = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 6));
        end
        cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
